// File: rtl/dcm_seq_pkg.sv
// Shared types and helpers for the DCM_SP lock/reset sequencer.
package dcm_seq_pkg;

  localparam int unsigned LOST_W  = 8;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    DCM_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  // Bits needed to hold the largest of three cycle counts.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dcm_reset_sequencer_sync_bit.sv
// N-flop async-reset synchroniser for a single level signal.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dcm_reset_sequencer.sv
// Drives DCM_SP RST from LOCKED and releases the system reset after a stable lock.
// Optional DCM_RESET_SEQ_FAIL_EN: give up in a terminal FAIL state after MAX_RETRIES timeouts.
module dcm_reset_sequencer
  import dcm_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DCM_RST_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned HOLD_CYCLES    = 1024,
  parameter int unsigned MAX_RETRIES    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               locked_i,
  output logic               dcm_rst_o,
  output logic               sys_rst_n_o,
  output logic               lock_lost_o,
  output logic [LOST_W-1:0]  lost_count_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned CNT_W = cnt_width(LOCK_TIMEOUT, HOLD_CYCLES, DCM_RST_CYCLES);

  // Reject parameter sets the sequencer cannot honour.
  if (SYNC_STAGES < 2 || DCM_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || HOLD_CYCLES < 1 ||
      MAX_RETRIES < 1) begin : g_bad_params
    $error("dcm_reset_sequencer: illegal parameter value");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              dcm_rst_q, dcm_rst_d;
  logic              sys_rst_n_q, sys_rst_n_d;
  logic              lock_lost_q, lock_lost_d;
  logic              locked_s;

`ifdef DCM_RESET_SEQ_FAIL_EN
  localparam int unsigned RETRY_W = cnt_width(MAX_RETRIES, 0, 0);
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (locked_i),
    .q_o   (locked_s)
  );

  // Next state; outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lost_d      = lost_q;
    lock_lost_d = 1'b0;
`ifdef DCM_RESET_SEQ_FAIL_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      DCM_RST: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(DCM_RST_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (locked_s) begin
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
`ifdef DCM_RESET_SEQ_FAIL_EN
          if (retry_q == RETRY_W'(MAX_RETRIES - 1)) begin
            state_d = FAIL;
          end else begin
            state_d = DCM_RST;
            retry_d = RETRY_W'(retry_q + 1'b1);
          end
`else
          state_d = DCM_RST;
`endif
        end
      end
      HOLD: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (!locked_s) begin
          state_d = DCM_RST;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
`ifdef DCM_RESET_SEQ_FAIL_EN
          retry_d = '0;
`endif
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d     = DCM_RST;
          lock_lost_d = 1'b1;
          if (lost_q != '1) lost_d = LOST_W'(lost_q + 1'b1);
        end
      end
`ifdef DCM_RESET_SEQ_FAIL_EN
      FAIL: state_d = FAIL;
`endif
      default: state_d = DCM_RST;
    endcase

    if (state_d != state_q) cnt_d = '0;

    dcm_rst_d   = (state_d == DCM_RST) || (state_d == FAIL);
    sys_rst_n_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DCM_RST;
      cnt_q       <= '0;
      lost_q      <= '0;
      dcm_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lost_q      <= lost_d;
      dcm_rst_q   <= dcm_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      lock_lost_q <= lock_lost_d;
    end
  end

`ifdef DCM_RESET_SEQ_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign dcm_rst_o    = dcm_rst_q;
  assign sys_rst_n_o  = sys_rst_n_q;
  assign lock_lost_o  = lock_lost_q;
  assign lost_count_o = lost_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Self-checking bench for dcm_reset_sequencer: directed vectors, corner sequences, random lock patterns.
module tb_dcm_reset_sequencer;

  localparam int SYNC_STAGES    = 2;
  localparam int DCM_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int HOLD_CYCLES    = 8;
  localparam int MAX_RETRIES    = 3;

  localparam int S_DCM_RST = 0;
  localparam int S_WAIT    = 1;
  localparam int S_HOLD    = 2;
  localparam int S_RUN     = 3;
  localparam int S_FAIL    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked_i;
  logic       dcm_rst_o;
  logic       sys_rst_n_o;
  logic       lock_lost_o;
  logic [7:0] lost_count_o;
  logic [2:0] state_o;

  always #10 clk = ~clk;

  dcm_reset_sequencer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DCM_RST_CYCLES (DCM_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked_i     (locked_i),
    .dcm_rst_o    (dcm_rst_o),
    .sys_rst_n_o  (sys_rst_n_o),
    .lock_lost_o  (lock_lost_o),
    .lost_count_o (lost_count_o),
    .state_o      (state_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sys_high_cnt = 0;
  int pulse_cnt    = 0;

  // Reference model: spec rules in terms of a mode and the cycles spent in it.
  int m_mode, m_age, m_retry, m_lost;
  bit m_pulse;
  bit m_pipe [SYNC_STAGES];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = S_DCM_RST; m_age = 0; m_retry = 0; m_lost = 0; m_pulse = 0;
    for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = 1'b0;
  endtask

  task automatic model_step(input bit lk);
    bit ls;
    int nxt;
    ls = m_pipe[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = lk;
    m_pulse = 1'b0;
    nxt = m_mode;
    case (m_mode)
      S_DCM_RST: if (m_age == DCM_RST_CYCLES - 1) nxt = S_WAIT;
      S_WAIT: begin
        if (ls) nxt = S_HOLD;
        else if (m_age == LOCK_TIMEOUT - 1) begin
          m_retry++;
          nxt = S_DCM_RST;
`ifdef DCM_RESET_SEQ_FAIL_EN
          if (m_retry >= MAX_RETRIES) nxt = S_FAIL;
`endif
        end
      end
      S_HOLD: begin
        if (!ls) nxt = S_DCM_RST;
        else if (m_age == HOLD_CYCLES - 1) begin
          nxt = S_RUN;
          m_retry = 0;
        end
      end
      S_RUN: begin
        if (!ls) begin
          nxt = S_DCM_RST;
          m_pulse = 1'b1;
          if (m_lost < 255) m_lost++;
        end
      end
      default: ;
    endcase
    m_age  = (nxt == m_mode) ? m_age + 1 : 0;
    m_mode = nxt;
  endtask

  // One clock: drive locked_i, step the model at the edge, compare just after it.
  task automatic cycle(input bit lk);
    locked_i = lk;
    @(posedge clk);
    model_step(lk);
    cyc++;
    #1;
    if (sys_rst_n_o === 1'b1) sys_high_cnt++;
    if (lock_lost_o === 1'b1) pulse_cnt++;
    check("model dcm_rst_o",    dcm_rst_o,    (m_mode == S_DCM_RST || m_mode == S_FAIL));
    check("model sys_rst_n_o",  sys_rst_n_o,  (m_mode == S_RUN));
    check("model lock_lost_o",  lock_lost_o,  m_pulse);
    check("model lost_count_o", lost_count_o, m_lost);
    check("model state_o",      state_o,      m_mode);
  endtask

  task automatic run_until(input bit lk, input int st, input int budget, input string name);
    int n;
    n = 0;
    while (state_o !== 3'(st) && n < budget) begin
      cycle(lk);
      n++;
    end
    check(name, state_o, st);
  endtask

  // Assert rst_n between edges and confirm the asynchronous reset values.
  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, " dcm_rst_o"},    dcm_rst_o,    1);
    check({tag, " sys_rst_n_o"},  sys_rst_n_o,  0);
    check({tag, " lock_lost_o"},  lock_lost_o,  0);
    check({tag, " lost_count_o"}, lost_count_o, 0);
    check({tag, " state_o"},      state_o,      S_DCM_RST);
    @(negedge clk);
    @(negedge clk);
    locked_i = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit lk;
    int n;
    int st;
    bit dcm;
    bit sysn;
    bit pulse;
    int lost;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int lows, highs;

    // Power-up lock, then a 5-cycle lock drop and reacquire, counted from rst_n release.
    tbl[0]  = '{1'b0, 3,  S_DCM_RST, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1,  S_WAIT,    1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 6,  S_WAIT,    1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 10, S_HOLD,    1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1,  S_RUN,     1'b0, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b0, 2,  S_RUN,     1'b0, 1'b1, 1'b0, 0};
    tbl[6]  = '{1'b0, 1,  S_DCM_RST, 1'b1, 1'b0, 1'b1, 1};
    tbl[7]  = '{1'b0, 2,  S_DCM_RST, 1'b1, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b1, 1,  S_DCM_RST, 1'b1, 1'b0, 1'b0, 1};
    tbl[9]  = '{1'b1, 1,  S_WAIT,    1'b0, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b1, 8,  S_HOLD,    1'b0, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b1, 1,  S_RUN,     1'b0, 1'b1, 1'b0, 1};

    rst_n = 1'b0;
    locked_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset dcm_rst_o",    dcm_rst_o,    1);
    check("reset sys_rst_n_o",  sys_rst_n_o,  0);
    check("reset lock_lost_o",  lock_lost_o,  0);
    check("reset lost_count_o", lost_count_o, 0);
    check("reset state_o",      state_o,      S_DCM_RST);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].lk);
      check($sformatf("vec%0d state_o", i),      state_o,      tbl[i].st);
      check($sformatf("vec%0d dcm_rst_o", i),    dcm_rst_o,    tbl[i].dcm);
      check($sformatf("vec%0d sys_rst_n_o", i),  sys_rst_n_o,  tbl[i].sysn);
      check($sformatf("vec%0d lock_lost_o", i),  lock_lost_o,  tbl[i].pulse);
      check($sformatf("vec%0d lost_count_o", i), lost_count_o, tbl[i].lost);
    end

    // Lock drop while in HOLD with cnt==5: back to DCM_RST, not counted as a loss.
    repeat (3) cycle(1'b0);
    check("run loss lost_count_o", lost_count_o, 2);
    run_until(1'b1, S_HOLD, 30, "reach hold");
    pulse_cnt = 0;
    repeat (3) cycle(1'b1);
    repeat (2) cycle(1'b0);
    check("hold cnt5 state_o", state_o, S_HOLD);
    cycle(1'b0);
    check("hold drop state_o", state_o, S_DCM_RST);
    check("hold drop lost_count_o", lost_count_o, 2);
    check("hold drop pulses", pulse_cnt, 0);

    // Lock one cycle too late for cnt==31 times out; exactly on cnt==31 wins.
    run_until(1'b0, S_WAIT, 20, "reach wait a");
    repeat (30) cycle(1'b0);
    repeat (2) cycle(1'b1);
    check("late lock timeout state_o", state_o, S_DCM_RST);
    run_until(1'b0, S_WAIT, 20, "reach wait b");
    repeat (29) cycle(1'b0);
    repeat (2) cycle(1'b1);
    check("cnt31 still waiting", state_o, S_WAIT);
    cycle(1'b1);
    check("cnt31 lock wins state_o", state_o, S_HOLD);
    check("cnt31 lock wins dcm_rst_o", dcm_rst_o, 0);
    run_until(1'b1, S_RUN, 20, "reach run");

    // Lock never returns: 32-low / 4-high DCM reset pattern, no system release.
    sys_high_cnt = 0;
    run_until(1'b0, S_DCM_RST, 10, "loss to dcm_rst");
    sys_high_cnt = 0;
    run_until(1'b0, S_WAIT, 10, "dcm_rst to wait");
    lows = 0;
    while (dcm_rst_o === 1'b0 && lows < 100) begin cycle(1'b0); lows++; end
    check("timeout low run", lows, LOCK_TIMEOUT);
    highs = 0;
    while (dcm_rst_o === 1'b1 && highs < 100) begin cycle(1'b0); highs++; end
    check("dcm_rst high run", highs, DCM_RST_CYCLES);
    repeat (120) cycle(1'b0);
    check("no sys release", sys_high_cnt, 0);
`ifdef DCM_RESET_SEQ_FAIL_EN
    check("fail state_o", state_o, S_FAIL);
    check("fail dcm_rst_o", dcm_rst_o, 1);
`else
    check("no fail state", (state_o == 3'd4), 0);
`endif

    // Saturate the loss counter, then reset asynchronously in the middle of HOLD.
    apply_reset("rst before saturate");
    for (int i = 0; i < 300; i++) begin
      run_until(1'b1, S_RUN, 40, "saturate reach run");
      repeat (3) cycle(1'b0);
      if (i == 254) check("lost_count_o at 255 losses", lost_count_o, 255);
    end
    check("lost_count_o saturated", lost_count_o, 255);
    run_until(1'b1, S_HOLD, 40, "reach hold for reset");
    repeat (3) cycle(1'b1);
    apply_reset("mid-hold async reset");

    // Random lock patterns, including single-cycle glitches.
    for (int s = 0; s < 60; s++) begin
      bit lk;
      int len;
      lk  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 50));
      for (int k = 0; k < len; k++) cycle(lk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
